// File: rtl/tick_uart_pkg.sv
// Shared types and line constants for the tick-driven UART transmitter.
package tick_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/tick_bit_timer.sv
// Counts enable pulses and flags the last one of each bit period.
// bit_done is combinational so the FSM can leave the bit on the same edge
// that consumes the final tick.
module tick_bit_timer #(
  parameter int unsigned TICKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_done
);

  localparam int unsigned CNT_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             at_last;

  assign at_last  = (cnt_q == CNT_LAST);
  assign bit_done = en && at_last;

  // Tick counter: cleared on accept, wraps at the end of each bit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (at_last) cnt_q <= '0;
      else         cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tick_uart_tx.sv
// Tick-paced asynchronous serial transmitter with valid/ready input.
// Optional even parity bit: define TICK_UART_TX_PARITY_EN.
module tick_uart_tx
  import tick_uart_pkg::*;
#(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned TICKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_W);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_W - 1);

  tx_state_t             state_q, state_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  tx_d, busy_d, in_ready_d;
  logic                  accept;
  logic                  bit_done;
`ifdef TICK_UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign accept = in_valid && in_ready;

  tick_bit_timer #(
    .TICKS_PER_BIT(TICKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (tick && busy),
    .bit_done (bit_done)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx        <= LINE_IDLE;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
`ifdef TICK_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx        <= tx_d;
      busy      <= busy_d;
      in_ready  <= in_ready_d;
`ifdef TICK_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state, datapath update and next output values.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef TICK_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = in_data;
          bit_cnt_d = '0;
`ifdef TICK_UART_TX_PARITY_EN
          parity_d  = ^in_data;
`endif
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
`ifdef TICK_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
`ifdef TICK_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = LINE_START;
      DATA:    tx_d = shift_d[0];
`ifdef TICK_UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = LINE_IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_tick_uart_tx.sv
// Directed self-checking bench for tick_uart_tx (TICKS_PER_BIT=4 and =1).
module tb_tick_uart_tx;

  localparam int DW  = 8;
  localparam int TPB = 4;
`ifdef TICK_UART_TX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int NTICKS = NBITS * TPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          tick_en = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, tx, busy;

  logic [DW-1:0] in_data1 = '0;
  logic          in_valid1 = 1'b0;
  logic          in_ready1, tx1, busy1;

  int errors = 0;
  int checks = 0;
  int phase  = 0;

  logic samp [0:63];
  int   nsamp;
  int   ncyc;

  always #5 clk = ~clk;

  tick_uart_tx #(.DATA_W(DW), .TICKS_PER_BIT(TPB)) dut (
    .clk(clk), .rst(rst), .tick(tick), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy)
  );

  tick_uart_tx #(.DATA_W(DW), .TICKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .tick(1'b1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx(tx1), .busy(busy1)
  );

  // Tick every 4 clocks, changed 2 time units after the posedge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      phase = (phase + 1) % 4;
      tick  = tick_en && (phase == 3);
    end
  end

  // Expected line level per bit index: start, data LSB first, [parity], stop.
  function automatic logic [15:0] frame_of(input logic [DW-1:0] w);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = w[i];
`ifdef TICK_UART_TX_PARITY_EN
    f[DW+1] = ^w;
`endif
    return f;
  endfunction

  // Present a word and confirm it is accepted on the next edge.
  task automatic start_word(input string name, input logic [DW-1:0] w, input bit hold);
    @(negedge clk);
    for (int i = 0; i < 400 && !in_ready; i++) @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%b tx=%b in_ready=%b, required 1 0 0", name, busy, tx, in_ready);
    end
  endtask

  // Record tx once per tick until busy drops; optionally disturb in_data.
  task automatic capture_frame(input bit toggle, input logic [DW-1:0] next_word);
    bit done;
    done  = 1'b0;
    nsamp = 0;
    ncyc  = 0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
      end else begin
        if (tick) begin
          if (nsamp < 64) samp[nsamp] = tx;
          nsamp++;
        end
        ncyc++;
        if (toggle) begin
          if (ncyc == 30)  in_data = 8'hFF;
          if (ncyc == 70)  in_data = 8'h00;
          if (ncyc == 110) in_data = next_word;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL capture timeout: busy=%b after %0d cycles, required 0", busy, ncyc);
    end
  endtask

  task automatic check_frame(input string name, input logic [DW-1:0] w);
    logic [15:0] exp;
    int bad;
    exp = frame_of(w);
    bad = 0;
    checks++;
    if (nsamp !== NTICKS) begin
      errors++;
      $display("FAIL %s ticks: got %0d, required %0d", name, nsamp, NTICKS);
    end
    for (int i = 0; i < NTICKS && i < 64; i++) if (samp[i] !== exp[i/TPB]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s bits: %0d tick samples wrong, required 0", name, bad);
    end
    checks++;
    if (ncyc < NTICKS*TPB - 3 || ncyc > NTICKS*TPB) begin
      errors++;
      $display("FAIL %s length: got %0d clk, required %0d..%0d", name, ncyc, NTICKS*TPB-3, NTICKS*TPB);
    end
    checks++;
    if (in_ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end: in_ready=%b tx=%b busy=%b, required 1 1 0", name, in_ready, tx, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || in_ready1 !== 1'b0) begin
      errors++;
      $display("FAIL reset values: tx=%b in_ready=%b busy=%b in_ready1=%b, required 1 0 0 0",
               tx, in_ready, busy, in_ready1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL first ready: in_ready=%b in_ready1=%b, required 1 1", in_ready, in_ready1);
    end
  endtask

  task automatic test_single_word();
    logic [NBITS-1:0] got;
    start_word("single", 8'hA5, 1'b0);
    capture_frame(1'b0, '0);
    check_frame("single", 8'hA5);
    for (int i = 0; i < NBITS; i++) got[i] = samp[i*TPB + 1];
    checks++;
`ifdef TICK_UART_TX_PARITY_EN
    if (got !== 11'b10101001010) begin
`else
    if (got !== 10'b1101001010) begin
`endif
      errors++;
      $display("FAIL single pattern: got %b (bit0 at right)", got);
    end
  endtask

  task automatic test_parity();
    start_word("parity07", 8'h07, 1'b0);
    capture_frame(1'b0, '0);
    check_frame("parity07", 8'h07);
`ifdef TICK_UART_TX_PARITY_EN
    checks++;
    if (samp[(DW+1)*TPB + 2] !== 1'b1) begin
      errors++;
      $display("FAIL parity07 bit: got %b, required 1", samp[(DW+1)*TPB + 2]);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int ticks;
    int bad;
    ticks = 0;
    start_word("midrst", 8'hA5, 1'b0);
    for (int c = 0; c < 200 && ticks < 17; c++) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst bit3: tx=%b busy=%b, required 0 1", tx, busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst forced: tx=%b busy=%b in_ready=%b, required 1 0 0", tx, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst ready: in_ready=%b, required 1", in_ready);
    end
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst residue: %0d non-idle cycles, required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    start_word("b2b1", 8'h3C, 1'b1);
    capture_frame(1'b1, 8'hC3);
    check_frame("b2b1", 8'h3C);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      errors++;
      $display("FAIL b2b gap: busy=%b tx=%b one clk after stop, required 1 0", busy, tx);
    end
    capture_frame(1'b0, '0);
    check_frame("b2b2", 8'hC3);
  endtask

  task automatic test_tick_in_accept();
    @(negedge clk);
    for (int i = 0; i < 20 && !(tick && in_ready); i++) @(negedge clk);
    in_data  = 8'h96;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    capture_frame(1'b0, '0);
    check_frame("acctick", 8'h96);
    checks++;
    if (ncyc != NTICKS*TPB) begin
      errors++;
      $display("FAIL acctick length: got %0d clk, required %0d", ncyc, NTICKS*TPB);
    end
  endtask

  task automatic test_tpb1();
    logic [15:0] exp;
    int bad;
    exp = frame_of(8'hFF);
    bad = 0;
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready1; i++) @(negedge clk);
    in_data1  = 8'hFF;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    for (int k = 0; k < NBITS; k++) begin
      if (tx1 !== exp[k] || busy1 !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tpb1 frame: %0d wrong clocks, required 0", bad);
    end
    checks++;
    if (busy1 !== 1'b0 || in_ready1 !== 1'b1 || tx1 !== 1'b1) begin
      errors++;
      $display("FAIL tpb1 end: busy=%b in_ready=%b tx=%b, required 0 1 1", busy1, in_ready1, tx1);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_parity();
    test_reset_mid_frame();
    test_back_to_back();
    test_tick_in_accept();
    test_tpb1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
